// File: rtl/req_encoder4to2_pkg.sv
// req_encoder4to2_pkg: shared widths, types and helpers for the request encoder.
package req_encoder4to2_pkg;
  localparam int IDX_W = 2;
  localparam int N_REQ = 4;
  typedef logic [N_REQ-1:0] req_vec_t;
  typedef logic [IDX_W-1:0] idx_t;
  function automatic req_vec_t onehot(input idx_t idx);
    return req_vec_t'(1) << idx;
  endfunction
endpackage

// File: rtl/req_encoder4to2_prio_enc4.sv
// prio_enc4: combinational 4-to-2 encoder picking the first set bit at or after base.
import req_encoder4to2_pkg::*;
module prio_enc4 (
  input  req_vec_t vec,
  input  idx_t     base,
  output idx_t     idx,
  output logic     any
);
  logic [2*N_REQ-1:0] dbl;
  req_vec_t rot;
  idx_t off;
  always_comb begin
    dbl = {vec, vec} >> base;
    rot = dbl[N_REQ-1:0];
    off = rot[0] ? 2'd0 : rot[1] ? 2'd1 : rot[2] ? 2'd2 : 2'd3;
    idx = base + off;
    any = |vec;
  end
endmodule

// File: rtl/req_encoder4to2.sv
// req_encoder4to2: captures request strobes into a pending set and issues one encoded index per transfer.
import req_encoder4to2_pkg::*;
module req_encoder4to2 #(
  parameter bit RR = 1'b0
) (
  input  logic     clk,
  input  logic     rst_n,
  input  req_vec_t req,
  input  logic     out_ready,
  input  logic     clr_ovf,
  output logic     out_valid,
  output idx_t     out_idx,
  output req_vec_t pend,
  output logic     ovf
);
  idx_t last, base, enc_idx, sel;
  req_vec_t enc_vec, clr;
  logic enc_any, load, xfer, ovf_set;
  // Fixed priority feeds the encoder a bit-reversed vector so "first from 0" means "highest index".
  always_comb begin
    enc_vec = RR ? pend : {pend[0], pend[1], pend[2], pend[3]};
    base    = RR ? idx_t'(last + 2'd1) : 2'd0;
  end
  prio_enc4 u_enc (
    .vec  (enc_vec),
    .base (base),
    .idx  (enc_idx),
    .any  (enc_any)
  );
  always_comb begin
    sel     = RR ? enc_idx : ~enc_idx;
    load    = enc_any && (!out_valid || out_ready);
    xfer    = out_valid && out_ready;
    clr     = load ? onehot(sel) : '0;
    ovf_set = |(req & pend & ~clr);
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid <= 1'b0;
      out_idx   <= '0;
      pend      <= '0;
      ovf       <= 1'b0;
      last      <= 2'b11;
    end else begin
      pend <= (pend & ~clr) | req;
      ovf  <= ovf_set || (ovf && !clr_ovf);
      if (load) begin
        out_idx   <= sel;
        out_valid <= 1'b1;
        last      <= sel;
      end else if (xfer) begin
        out_valid <= 1'b0;
      end
    end
  end
endmodule

// File: tb/tb_req_encoder4to2.sv
// tb_req_encoder4to2: checks fixed-priority and round-robin encoders against a behavioural model.
module tb_req_encoder4to2;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic [3:0] req = '0;
  logic out_ready = 1'b0;
  logic clr_ovf = 1'b0;
  logic v0, v1, o0, o1;
  logic [1:0] i0, i1;
  logic [3:0] p0, p1;
  logic [7:0] obs [2];
  int total = 0;
  int bad = 0;
  logic mv [2];
  logic mo [2];
  logic [1:0] mi [2];
  logic [1:0] ml [2];
  logic [3:0] mp [2];

  always #5 clk = ~clk;

  req_encoder4to2 #(.RR(1'b0)) dut0 (
    .clk(clk), .rst_n(rst_n), .req(req), .out_ready(out_ready), .clr_ovf(clr_ovf),
    .out_valid(v0), .out_idx(i0), .pend(p0), .ovf(o0)
  );
  req_encoder4to2 #(.RR(1'b1)) dut1 (
    .clk(clk), .rst_n(rst_n), .req(req), .out_ready(out_ready), .clr_ovf(clr_ovf),
    .out_valid(v1), .out_idx(i1), .pend(p1), .ovf(o1)
  );

  assign obs[0] = {v0, i0, p0, o0};
  assign obs[1] = {v1, i1, p1, o1};

  function automatic logic [7:0] expv(input int m);
    return {mv[m], mi[m], mp[m], mo[m]};
  endfunction

  task automatic model_reset();
    for (int m = 0; m < 2; m++) begin
      mv[m] = 1'b0; mo[m] = 1'b0; mi[m] = 2'd0; ml[m] = 2'd3; mp[m] = 4'd0;
    end
  endtask

  // Model of one clock edge: search order from the rules, not from any register encoding.
  task automatic model_step(input logic [3:0] r, input logic rd, input logic c);
    for (int m = 0; m < 2; m++) begin
      logic ld, lost, found;
      int s;
      logic [3:0] np;
      ld = (mp[m] != 0) && (!mv[m] || rd);
      s = 0; found = 1'b0; lost = 1'b0;
      if (m == 0) begin
        for (int i = 3; i >= 0; i--) if (!found && mp[m][i]) begin s = i; found = 1'b1; end
      end else begin
        for (int k = 1; k <= 4; k++) begin
          int j;
          j = (int'(ml[m]) + k) % 4;
          if (!found && mp[m][j]) begin s = j; found = 1'b1; end
        end
      end
      for (int i = 0; i < 4; i++) if (r[i] && mp[m][i] && !(ld && s == i)) lost = 1'b1;
      np = mp[m];
      if (ld) np[s] = 1'b0;
      np = np | r;
      if (ld) begin mi[m] = s[1:0]; mv[m] = 1'b1; ml[m] = s[1:0]; end
      else if (mv[m] && rd) mv[m] = 1'b0;
      mo[m] = lost ? 1'b1 : (c ? 1'b0 : mo[m]);
      mp[m] = np;
    end
  endtask

  task automatic drive(input logic [3:0] r, input logic rd, input logic c);
    req = r; out_ready = rd; clr_ovf = c;
    model_step(r, rd, c);
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst_n = 1'b0; req = '0; out_ready = 1'b0; clr_ovf = 1'b0;
    model_reset();
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    do_reset();
    for (int m = 0; m < 2; m++) begin
      total++;
      if (obs[m] !== 8'h00) begin
        bad++;
        $display("FAIL reset dut%0d: got %b want %b", m, obs[m], 8'h00);
      end
    end
  endtask

  task automatic test_fixed_prio();
    logic [1:0] want [2];
    want[0] = 2'd2; want[1] = 2'd0;
    do_reset();
    drive(4'b0101, 1'b1, 1'b0);
    for (int c = 0; c < 3; c++) begin
      drive(4'b0000, 1'b1, 1'b0);
      if (c < 2) begin
        total++;
        if (!v0 || i0 !== want[c]) begin
          bad++;
          $display("FAIL fixed_seq[%0d]: got valid=%b idx=%0d want valid=1 idx=%0d", c, v0, i0, want[c]);
        end
      end
      for (int m = 0; m < 2; m++) begin
        total++;
        if (obs[m] !== expv(m)) begin
          bad++;
          $display("FAIL fixed_model dut%0d cyc%0d: got %b want %b", m, c, obs[m], expv(m));
        end
      end
    end
  endtask

  task automatic test_backpressure();
    do_reset();
    drive(4'b1000, 1'b0, 1'b0);
    drive(4'b0010, 1'b0, 1'b0);
    drive(4'b0000, 1'b0, 1'b0);
    total++;
    if (!v0 || i0 !== 2'd3 || p0 !== 4'b0010) begin
      bad++;
      $display("FAIL bp_hold: got valid=%b idx=%0d pend=%b want valid=1 idx=3 pend=0010", v0, i0, p0);
    end
    drive(4'b0000, 1'b1, 1'b0);
    total++;
    if (!v0 || i0 !== 2'd1) begin
      bad++;
      $display("FAIL bp_release: got valid=%b idx=%0d want valid=1 idx=1", v0, i0);
    end
    drive(4'b0000, 1'b1, 1'b0);
    for (int m = 0; m < 2; m++) begin
      total++;
      if (obs[m] !== expv(m)) begin
        bad++;
        $display("FAIL bp_model dut%0d: got %b want %b", m, obs[m], expv(m));
      end
    end
  endtask

  task automatic test_round_robin();
    do_reset();
    drive(4'b1111, 1'b1, 1'b0);
    for (int c = 0; c < 8; c++) begin
      drive(4'b1111, 1'b1, 1'b0);
      total++;
      if (!v1 || i1 !== 2'(c % 4) || o1 !== 1'b1) begin
        bad++;
        $display("FAIL rr_seq[%0d]: got valid=%b idx=%0d ovf=%b want valid=1 idx=%0d ovf=1", c, v1, i1, o1, c % 4);
      end
      total++;
      if (obs[0] !== expv(0)) begin
        bad++;
        $display("FAIL rr_fixed_model cyc%0d: got %b want %b", c, obs[0], expv(0));
      end
    end
  endtask

  task automatic test_overflow();
    do_reset();
    drive(4'b0100, 1'b0, 1'b0);
    drive(4'b0010, 1'b0, 1'b0);
    drive(4'b0010, 1'b0, 1'b0);
    total++;
    if (o0 !== 1'b1 || i0 !== 2'd2 || o1 !== 1'b1) begin
      bad++;
      $display("FAIL ovf_set: got ovf0=%b idx0=%0d ovf1=%b want 1 2 1", o0, i0, o1);
    end
    drive(4'b0000, 1'b0, 1'b1);
    total++;
    if (o0 !== 1'b0 || o1 !== 1'b0) begin
      bad++;
      $display("FAIL ovf_clr: got ovf0=%b ovf1=%b want 0 0", o0, o1);
    end
    drive(4'b0010, 1'b0, 1'b1);
    total++;
    if (o0 !== 1'b1 || o1 !== 1'b1) begin
      bad++;
      $display("FAIL ovf_set_wins: got ovf0=%b ovf1=%b want 1 1", o0, o1);
    end
  endtask

  task automatic test_same_edge();
    do_reset();
    drive(4'b0100, 1'b1, 1'b0);
    drive(4'b0100, 1'b1, 1'b0);
    total++;
    if (!v0 || i0 !== 2'd2 || p0 !== 4'b0100 || o0 !== 1'b0) begin
      bad++;
      $display("FAIL same_edge: got valid=%b idx=%0d pend=%b ovf=%b want 1 2 0100 0", v0, i0, p0, o0);
    end
    drive(4'b0000, 1'b1, 1'b0);
    total++;
    if (!v1 || i1 !== 2'd2 || p1 !== 4'b0000) begin
      bad++;
      $display("FAIL same_edge_reissue: got valid=%b idx=%0d pend=%b want 1 2 0000", v1, i1, p1);
    end
  endtask

  task automatic test_reset_mid();
    do_reset();
    drive(4'b1010, 1'b0, 1'b0);
    drive(4'b0000, 1'b0, 1'b0);
    drive(4'b1000, 1'b0, 1'b0);
    total++;
    if (!v0 || p0 !== 4'b1010) begin
      bad++;
      $display("FAIL mid_setup: got valid=%b pend=%b want 1 1010", v0, p0);
    end
    #2;
    rst_n = 1'b0;
    model_reset();
    #1;
    for (int m = 0; m < 2; m++) begin
      total++;
      if (obs[m] !== 8'h00) begin
        bad++;
        $display("FAIL mid_reset dut%0d: got %b want %b", m, obs[m], 8'h00);
      end
    end
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
  endtask

  task automatic test_random();
    do_reset();
    for (int c = 0; c < 400; c++) begin
      logic [3:0] r;
      r = ($urandom_range(0, 2) == 0) ? 4'($urandom) : 4'b0000;
      drive(r, 1'($urandom_range(0, 3) != 0), 1'($urandom_range(0, 7) == 0));
      for (int m = 0; m < 2; m++) begin
        total++;
        if (obs[m] !== expv(m)) begin
          bad++;
          $display("FAIL random dut%0d cyc%0d: got %b want %b", m, c, obs[m], expv(m));
        end
      end
    end
  endtask

  initial begin
    test_reset();
    test_fixed_prio();
    test_backpressure();
    test_round_robin();
    test_overflow();
    test_same_edge();
    test_reset_mid();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
